zap_tag_lookup_ctrl: RTL and testbench
======================================

Name: zap_tag_lookup_ctrl

Overview:
- Controller that owns both ports of a single-cycle-clear tag RAM used by the TLB/cache tag stores.
- Accepts lookup requests, reads the tag RAM through its early (2-cycle) read path and compares tags.
- On a miss, requests a line fill, writes the new tag when the fill completes and replays the lookup.
- Also sequences whole-array invalidate requests into the tag RAM's one-cycle clear.

Parameters:
- DEPTH, 32, tag RAM entries; power of 2, minimum 2.
- ADDR_WIDTH, 32, request address width.
- OFFSET_BITS, 4, line-offset bits ignored by lookup.
- TAG_WIDTH, ADDR_WIDTH-OFFSET_BITS-$clog2(DEPTH), derived; tag RAM data width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_req_valid  in  1  lookup request valid.
- o_req_ready  out  1  high only in IDLE with i_inv_req low.
- i_req_addr  in  ADDR_WIDTH  lookup address.
- o_resp_valid  out  1  response valid; held until i_resp_ready.
- i_resp_ready  in  1  response accept.
- o_resp_hit  out  1  hit on first lookup (no fill).
- o_resp_err  out  1  fill returned error.
- o_raddr  out  $clog2(DEPTH)  tag RAM read address.
- i_rdata_pre  in  TAG_WIDTH  tag RAM early read data.
- i_rdav_pre  in  1  tag RAM early valid.
- o_wen  out  1  tag RAM write enable.
- o_waddr  out  $clog2(DEPTH)  tag RAM write address.
- o_wdata  out  TAG_WIDTH  tag RAM write data.
- o_inv  out  1  tag RAM single-cycle invalidate.
- i_inv_req  in  1  invalidate request (level).
- o_inv_ack  out  1  one-cycle pulse, same cycle as o_inv.
- o_fill_req  out  1  fill request, held until i_fill_ack.
- o_fill_addr  out  ADDR_WIDTH  line address; offset bits zeroed.
- i_fill_ack  in  1  fill accepted.
- i_fill_done  in  1  fill complete pulse.
- i_fill_err  in  1  qualifies i_fill_done as an error.
- o_miss_cnt  out  16  saturating miss counter.

Behaviour:
- Address split: index = addr[OFFSET_BITS +: $clog2(DEPTH)]; tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH].
- The tag RAM clken is tied high at integration. Early read data is valid in the cycle two edges after o_raddr is presented.
- Reset: state IDLE. All outputs are 0 (o_req_ready is 0 during reset and 1 in the first cycle after it), o_miss_cnt=0, latched address=0.
- Reset mid-fill drops o_fill_req immediately. A stale i_fill_done after reset is ignored.
- States:
  - IDLE: if i_inv_req, go to INV; else if i_req_valid, latch the address, set first_try=1 and go to RD0.
  - INV: o_inv=o_inv_ack=1 for exactly one cycle, then IDLE.
  - RD0, RD1: o_raddr=latched index.
  - CMP: hit = i_rdav_pre && i_rdata_pre==tag.
    - Hit: go to RESP with o_resp_hit=first_try, o_resp_err=0.
    - Miss on first_try: increment o_miss_cnt (saturates at 16'hFFFF) and go to FILL.
    - Miss on replay: protocol error; go to RESP with o_resp_err=1.
  - FILL: o_fill_req=1 until i_fill_ack (ack may arrive in the first FILL cycle), then FWAIT.
  - FWAIT: on i_fill_done with i_fill_err=1, go to RESP with o_resp_err=1 and do not write the tag. On i_fill_done without error, go to WR.
  - WR: o_wen=1 for one cycle with waddr=index and wdata=tag; clear first_try; go to RD0.
  - RESP: o_resp_valid=1 until i_resp_ready, then IDLE. Outputs stay stable while stalled.
- Latency, acceptance edge at N:
  - Hit: o_resp_valid high from cycle N+4.
  - Miss: response 4 cycles after the WR cycle.
- i_inv_req arriving while busy waits until IDLE. If i_inv_req and i_req_valid are both set in IDLE, the invalidate wins and the request is not accepted.
- i_fill_done outside FWAIT is ignored.
- o_raddr and o_waddr hold the latched index in all states; o_wdata holds the latched tag.

Test Plan:
1. After reset, invalidate, then lookup 0x0000_1230 → miss; o_fill_req with o_fill_addr=0x0000_1230; ack and done → o_wen with waddr=3, wdata=0x00009; response hit=0, err=0; o_miss_cnt=1.
2. Repeat lookup 0x0000_1234 → o_resp_valid in cycle N+4, hit=1, no fill; o_miss_cnt stays 1.
3. Lookup 0x0000_5230 (same index 3, tag 0x00029) → miss; fill completes with err=1 → err=1 response, no o_wen, o_miss_cnt=2.
4. Assert i_inv_req while in FWAIT → o_inv not issued until after RESP handshake completes; then o_inv is a one-cycle pulse; the following lookup of 0x0000_1230 misses.
5. Hold i_resp_ready=0 for 5 cycles → o_resp_valid and o_resp_hit stay stable and o_req_ready=0.
6. Reset asserted in FILL with o_fill_req=1 → next cycle o_fill_req=0, state IDLE, o_miss_cnt=0; an i_fill_done arriving afterwards produces no o_wen.

Source files
------------

// File: rtl/zap_tag_lookup_ctrl_if.sv
// Bundle of the request/response, tag RAM, invalidate and fill signals
// of the tag lookup controller. The controller uses the slave modport;
// the surrounding system (requester, tag RAM, fill engine) uses master.
//
// Handshake semantics: on every valid/ready pair (req_valid/req_ready,
// resp_valid/resp_ready, fill_req/fill_ack) a transfer happens on a rising
// clock edge where both are high; the source holds valid and its payload
// stable until that edge, and ready may be asserted without waiting for valid.
interface zap_tag_lookup_ctrl_if #(
   parameter int DEPTH       = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 4,
   parameter int TAG_WIDTH   = ADDR_WIDTH - OFFSET_BITS - $clog2(DEPTH)
);
   localparam int IDX_W = $clog2(DEPTH);

   // Lookup request / response
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_hit;
   logic                  resp_err;

   // Tag RAM ports
   logic [IDX_W-1:0]      raddr;
   logic [TAG_WIDTH-1:0]  rdata_pre;
   logic                  rdav_pre;
   logic                  wen;
   logic [IDX_W-1:0]      waddr;
   logic [TAG_WIDTH-1:0]  wdata;
   logic                  inv;

   // Invalidate request
   logic                  inv_req;
   logic                  inv_ack;

   // Line fill
   logic                  fill_req;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic                  fill_ack;
   logic                  fill_done;
   logic                  fill_err;

   // Statistics
   logic [15:0]           miss_cnt;

   modport master (
      output req_valid, req_addr, resp_ready, rdata_pre, rdav_pre,
             inv_req, fill_ack, fill_done, fill_err,
      input  req_ready, resp_valid, resp_hit, resp_err, raddr, wen, waddr,
             wdata, inv, inv_ack, fill_req, fill_addr, miss_cnt
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, rdata_pre, rdav_pre,
             inv_req, fill_ack, fill_done, fill_err,
      output req_ready, resp_valid, resp_hit, resp_err, raddr, wen, waddr,
             wdata, inv, inv_ack, fill_req, fill_addr, miss_cnt
   );
endinterface

// File: rtl/zap_tag_lookup_ctrl.sv
// Tag lookup controller. Owns both ports of a single-cycle-clear tag RAM:
// reads it through the 2-cycle early read path, compares tags, on a miss
// requests a line fill, writes the new tag and replays the lookup. Whole-array
// invalidate requests are turned into the RAM's one-cycle clear while idle.
module zap_tag_lookup_ctrl #(
   parameter int DEPTH       = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int OFFSET_BITS = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   zap_tag_lookup_ctrl_if.slave     bus,
   output logic [3:0]               dbg_state
);
   localparam int IDX_W     = $clog2(DEPTH);
   localparam int LINE_W    = ADDR_WIDTH - OFFSET_BITS;
   localparam int TAG_WIDTH = LINE_W - IDX_W;

   // Reject unsupported depths at elaboration time.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("zap_tag_lookup_ctrl: DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_INV   = 4'd1,
      S_RD0   = 4'd2,
      S_RD1   = 4'd3,
      S_CMP   = 4'd4,
      S_FILL  = 4'd5,
      S_FWAIT = 4'd6,
      S_WR    = 4'd7,
      S_RESP  = 4'd8
   } state_t;

   state_t              state_q;
   logic [LINE_W-1:0]   line_q;        // latched address without offset bits
   logic                first_try_q;   // cleared once a fill has written the tag
   logic                resp_valid_q;
   logic                resp_hit_q;
   logic                resp_err_q;
   logic                fill_req_q;
   logic                wen_q;
   logic                inv_q;
   logic [15:0]         miss_q;

   logic [TAG_WIDTH-1:0] line_tag;
   logic [IDX_W-1:0]     line_idx;
   logic                 tag_hit;

   // Offset bits never take part in a lookup.
   logic unused_offset;
   assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

   // Field split of the latched line address and the tag compare.
   assign line_tag = line_q[LINE_W-1 -: TAG_WIDTH];
   assign line_idx = line_q[IDX_W-1:0];
   assign tag_hit  = bus.rdav_pre && (bus.rdata_pre == line_tag);

   // Main sequencer: every state-dependent output is a register set on the
   // transition into the state that owns it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         line_q       <= '0;
         first_try_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_err_q   <= 1'b0;
         fill_req_q   <= 1'b0;
         wen_q        <= 1'b0;
         inv_q        <= 1'b0;
         miss_q       <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Invalidate takes priority over a simultaneous lookup.
               if (bus.inv_req) begin
                  inv_q   <= 1'b1;
                  state_q <= S_INV;
               end else if (bus.req_valid) begin
                  line_q      <= bus.req_addr[ADDR_WIDTH-1:OFFSET_BITS];
                  first_try_q <= 1'b1;
                  state_q     <= S_RD0;
               end
            end
            S_INV: begin
               inv_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            S_RD0: state_q <= S_RD1;
            S_RD1: state_q <= S_CMP;
            S_CMP: begin
               if (tag_hit) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= first_try_q;
                  resp_err_q   <= 1'b0;
                  state_q      <= S_RESP;
               end else if (first_try_q) begin
                  if (miss_q != 16'hFFFF) begin
                     miss_q <= miss_q + 16'd1;
                  end
                  fill_req_q <= 1'b1;
                  state_q    <= S_FILL;
               end else begin
                  // A freshly written tag that still misses is a protocol error.
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= 1'b0;
                  resp_err_q   <= 1'b1;
                  state_q      <= S_RESP;
               end
            end
            S_FILL: begin
               if (bus.fill_ack) begin
                  fill_req_q <= 1'b0;
                  state_q    <= S_FWAIT;
               end
            end
            S_FWAIT: begin
               if (bus.fill_done) begin
                  if (bus.fill_err) begin
                     resp_valid_q <= 1'b1;
                     resp_hit_q   <= 1'b0;
                     resp_err_q   <= 1'b1;
                     state_q      <= S_RESP;
                  end else begin
                     wen_q   <= 1'b1;
                     state_q <= S_WR;
                  end
               end
            end
            S_WR: begin
               wen_q       <= 1'b0;
               first_try_q <= 1'b0;
               state_q     <= S_RD0;
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_hit_q   <= 1'b0;
                  resp_err_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Output mapping; RAM addresses and write data always follow the latched line.
   assign bus.req_ready  = (state_q == S_IDLE) && !bus.inv_req && !i_reset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_hit   = resp_hit_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.raddr      = line_idx;
   assign bus.waddr      = line_idx;
   assign bus.wdata      = line_tag;
   assign bus.wen        = wen_q;
   assign bus.inv        = inv_q;
   assign bus.inv_ack    = inv_q;
   assign bus.fill_req   = fill_req_q;
   assign bus.fill_addr  = {line_q, {OFFSET_BITS{1'b0}}};
   assign bus.miss_cnt   = miss_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_zap_tag_lookup_ctrl.sv
// Directed bench for zap_tag_lookup_ctrl with a small behavioural tag RAM.
module tb_zap_tag_lookup_ctrl;
   localparam int DEPTH = 32;
   localparam int AW    = 32;
   localparam int OB    = 4;
   localparam int IW    = 5;
   localparam int TW    = 23;

   localparam logic [3:0] ST_IDLE  = 4'd0;
   localparam logic [3:0] ST_INV   = 4'd1;
   localparam logic [3:0] ST_RD0   = 4'd2;
   localparam logic [3:0] ST_FILL  = 4'd5;
   localparam logic [3:0] ST_FWAIT = 4'd6;
   localparam logic [3:0] ST_WR    = 4'd7;
   localparam logic [3:0] ST_RESP  = 4'd8;

   logic       clk;
   logic       rst;
   logic [3:0] dbg_state;
   int         checks;
   int         errors;

   zap_tag_lookup_ctrl_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) bus ();

   zap_tag_lookup_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .OFFSET_BITS(OB)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural tag RAM: two-stage early read, write port, one-cycle clear.
   logic [TW-1:0] ram_tag [DEPTH];
   logic          ram_vld [DEPTH];
   logic [IW-1:0] rd_s1;
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram_tag[i] = '0;
         ram_vld[i] = 1'b0;
      end
   end
   always @(posedge clk) begin
      if (bus.inv) begin
         for (int i = 0; i < DEPTH; i++) ram_vld[i] <= 1'b0;
      end else if (bus.wen) begin
         ram_tag[bus.waddr] <= bus.wdata;
         ram_vld[bus.waddr] <= 1'b1;
      end
      rd_s1         <= bus.raddr;
      bus.rdata_pre <= ram_tag[rd_s1];
      bus.rdav_pre  <= ram_vld[rd_s1];
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one request at a negedge in IDLE; returns in the RD0 cycle.
   task automatic issue(input logic [AW-1:0] addr);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0h expected 0", bus.req_ready); end
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %0h expected 0", bus.resp_valid); end
      checks++; if (bus.fill_req !== 1'b0) begin errors++; $display("FAIL rst_fill_req: got %0h expected 0", bus.fill_req); end
      checks++; if (bus.wen !== 1'b0 || bus.inv !== 1'b0 || bus.inv_ack !== 1'b0) begin errors++; $display("FAIL rst_wen_inv: got %0h%0h%0h expected 000", bus.wen, bus.inv, bus.inv_ack); end
      checks++; if (bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_miss_cnt: got %0h expected 0", bus.miss_cnt); end
      checks++; if (bus.fill_addr !== 32'h0 || bus.raddr !== 5'd0) begin errors++; $display("FAIL rst_addr: got %0h/%0h expected 0/0", bus.fill_addr, bus.raddr); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0h expected %0h", dbg_state, ST_IDLE); end
      rst = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready: got %0h expected 1", bus.req_ready); end
   endtask

   // Invalidate, then a miss that fills and replays to a non-hit response.
   task automatic test_miss_fill();
      bus.inv_req = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL inv_req_ready: got %0h expected 0", bus.req_ready); end
      tick();
      checks++; if (bus.inv !== 1'b1 || bus.inv_ack !== 1'b1) begin errors++; $display("FAIL inv_pulse: got %0h%0h expected 11", bus.inv, bus.inv_ack); end
      bus.inv_req = 1'b0;
      tick();
      checks++; if (bus.inv !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL inv_end: got inv %0h state %0h expected 0/%0h", bus.inv, dbg_state, ST_IDLE); end
      issue(32'h0000_1230);
      checks++; if (dbg_state !== ST_RD0 || bus.raddr !== 5'd3) begin errors++; $display("FAIL m1_rd0: got state %0h raddr %0h expected %0h/3", dbg_state, bus.raddr, ST_RD0); end
      tick(); tick();
      checks++; if (bus.fill_req !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL m1_cmp: got %0h%0h expected 00", bus.fill_req, bus.resp_valid); end
      tick();
      checks++; if (bus.fill_req !== 1'b1 || bus.fill_addr !== 32'h0000_1230) begin errors++; $display("FAIL m1_fill_req: got %0h addr %0h expected 1/1230", bus.fill_req, bus.fill_addr); end
      checks++; if (bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL m1_miss_cnt: got %0h expected 1", bus.miss_cnt); end
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack = 1'b0;
      checks++; if (bus.fill_req !== 1'b0 || dbg_state !== ST_FWAIT) begin errors++; $display("FAIL m1_fwait: got %0h state %0h expected 0/%0h", bus.fill_req, dbg_state, ST_FWAIT); end
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      checks++; if (bus.wen !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 23'h00009) begin errors++; $display("FAIL m1_write: got wen %0h waddr %0h wdata %0h expected 1/3/9", bus.wen, bus.waddr, bus.wdata); end
      tick();
      checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL m1_wen_pulse: got %0h expected 0", bus.wen); end
      tick(); tick();
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL m1_resp_early: got %0h expected 0", bus.resp_valid); end
      tick();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL m1_resp: got v%0h h%0h e%0h expected v1 h0 e0", bus.resp_valid, bus.resp_hit, bus.resp_err); end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL m1_handshake: got v%0h state %0h expected v0/%0h", bus.resp_valid, dbg_state, ST_IDLE); end
   endtask

   // Second lookup of the same line hits with N+4 latency.
   task automatic test_hit();
      issue(32'h0000_1234);
      tick(); tick();
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL hit_early: got %0h expected 0", bus.resp_valid); end
      tick();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL hit_resp: got v%0h h%0h e%0h expected v1 h1 e0", bus.resp_valid, bus.resp_hit, bus.resp_err); end
      checks++; if (bus.fill_req !== 1'b0 || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL hit_no_fill: got fill %0h cnt %0h expected 0/1", bus.fill_req, bus.miss_cnt); end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   // Conflicting tag in the same index; the fill returns an error.
   task automatic test_fill_err();
      issue(32'h0000_5230);
      tick(); tick(); tick();
      checks++; if (bus.fill_req !== 1'b1 || bus.fill_addr !== 32'h0000_5230 || bus.miss_cnt !== 16'd2) begin errors++; $display("FAIL ferr_fill: got %0h addr %0h cnt %0h expected 1/5230/2", bus.fill_req, bus.fill_addr, bus.miss_cnt); end
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack  = 1'b0;
      bus.fill_done = 1'b1;
      bus.fill_err  = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      bus.fill_err  = 1'b0;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_hit !== 1'b0) begin errors++; $display("FAIL ferr_resp: got v%0h h%0h e%0h expected v1 h0 e1", bus.resp_valid, bus.resp_hit, bus.resp_err); end
      checks++; if (bus.wen !== 1'b0 || dbg_state !== ST_RESP) begin errors++; $display("FAIL ferr_no_wen: got wen %0h state %0h expected 0/%0h", bus.wen, dbg_state, ST_RESP); end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   // Invalidate raised while busy is deferred until the response completes.
   task automatic test_inv_deferred();
      issue(32'h0000_5230);
      tick(); tick(); tick();
      checks++; if (bus.miss_cnt !== 16'd3) begin errors++; $display("FAIL dinv_miss_cnt: got %0h expected 3", bus.miss_cnt); end
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack = 1'b0;
      bus.inv_req  = 1'b1;
      tick();
      checks++; if (bus.inv !== 1'b0 || dbg_state !== ST_FWAIT) begin errors++; $display("FAIL dinv_fwait: got inv %0h state %0h expected 0/%0h", bus.inv, dbg_state, ST_FWAIT); end
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      checks++; if (bus.wen !== 1'b1 || bus.wdata !== 23'h00029) begin errors++; $display("FAIL dinv_write: got wen %0h wdata %0h expected 1/29", bus.wen, bus.wdata); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.inv !== 1'b0) begin errors++; $display("FAIL dinv_busy_inv: got %0h expected 0", bus.inv); end
      end
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL dinv_resp: got v%0h h%0h e%0h expected v1 h0 e0", bus.resp_valid, bus.resp_hit, bus.resp_err); end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      checks++; if (dbg_state !== ST_IDLE || bus.inv !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL dinv_idle: got state %0h inv %0h rdy %0h expected %0h/0/0", dbg_state, bus.inv, bus.req_ready, ST_IDLE); end
      tick();
      checks++; if (bus.inv !== 1'b1 || bus.inv_ack !== 1'b1 || dbg_state !== ST_INV) begin errors++; $display("FAIL dinv_pulse: got %0h%0h state %0h expected 11/%0h", bus.inv, bus.inv_ack, dbg_state, ST_INV); end
      bus.inv_req = 1'b0;
      tick();
      checks++; if (bus.inv !== 1'b0) begin errors++; $display("FAIL dinv_pulse_end: got %0h expected 0", bus.inv); end
      // The array is now empty, so the line filled earlier misses again.
      issue(32'h0000_1230);
      tick(); tick(); tick();
      checks++; if (bus.fill_req !== 1'b1 || bus.miss_cnt !== 16'd4) begin errors++; $display("FAIL dinv_remiss: got fill %0h cnt %0h expected 1/4", bus.fill_req, bus.miss_cnt); end
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack  = 1'b0;
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      checks++; if (bus.wen !== 1'b1 || bus.wdata !== 23'h00009) begin errors++; $display("FAIL dinv_rewrite: got wen %0h wdata %0h expected 1/9", bus.wen, bus.wdata); end
      repeat (4) tick();
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b0) begin errors++; $display("FAIL dinv_reresp: got v%0h h%0h expected v1 h0", bus.resp_valid, bus.resp_hit); end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
   endtask

   // Response held under backpressure.
   task automatic test_stall();
      issue(32'h0000_1230);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.resp_valid !== 1'b1 || bus.resp_hit !== 1'b1 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL stall_hold: got v%0h h%0h e%0h r%0h expected v1 h1 e0 r0", bus.resp_valid, bus.resp_hit, bus.resp_err, bus.req_ready); end
         tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got v%0h r%0h expected v0 r1", bus.resp_valid, bus.req_ready); end
   endtask

   // Invalidate and request together: invalidate wins, request not latched.
   task automatic test_inv_priority();
      bus.inv_req   = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0040;
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready: got %0h expected 0", bus.req_ready); end
      tick();
      bus.inv_req   = 1'b0;
      bus.req_valid = 1'b0;
      checks++; if (dbg_state !== ST_INV || bus.inv !== 1'b1) begin errors++; $display("FAIL prio_state: got state %0h inv %0h expected %0h/1", dbg_state, bus.inv, ST_INV); end
      checks++; if (bus.raddr !== 5'd3 || bus.fill_addr !== 32'h0000_1230) begin errors++; $display("FAIL prio_not_latched: got raddr %0h addr %0h expected 3/1230", bus.raddr, bus.fill_addr); end
      tick();
      // A fill_done pulse while idle must be ignored.
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      checks++; if (bus.wen !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL stray_done: got wen %0h state %0h expected 0/%0h", bus.wen, dbg_state, ST_IDLE); end
   endtask

   // Reset during FILL drops the request; a late fill_done is ignored.
   task automatic test_reset_mid_fill();
      issue(32'h0000_5230);
      tick(); tick(); tick();
      checks++; if (bus.fill_req !== 1'b1 || dbg_state !== ST_FILL || bus.miss_cnt !== 16'd5) begin errors++; $display("FAIL rmf_fill: got %0h state %0h cnt %0h expected 1/%0h/5", bus.fill_req, dbg_state, bus.miss_cnt, ST_FILL); end
      rst = 1'b1;
      tick();
      checks++; if (bus.fill_req !== 1'b0 || dbg_state !== ST_IDLE || bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL rmf_reset: got %0h state %0h cnt %0h expected 0/%0h/0", bus.fill_req, dbg_state, bus.miss_cnt, ST_IDLE); end
      checks++; if (bus.fill_addr !== 32'h0 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL rmf_reset_addr: got addr %0h rdy %0h expected 0/0", bus.fill_addr, bus.req_ready); end
      rst = 1'b0;
      bus.fill_done = 1'b1;
      tick();
      bus.fill_done = 1'b0;
      checks++; if (bus.wen !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmf_stale_done: got wen %0h state %0h expected 0/%0h", bus.wen, dbg_state, ST_IDLE); end
      tick();
      checks++; if (bus.wen !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmf_settle: got wen %0h rdy %0h expected 0/1", bus.wen, bus.req_ready); end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.resp_ready = 1'b0;
      bus.inv_req    = 1'b0;
      bus.fill_ack   = 1'b0;
      bus.fill_done  = 1'b0;
      bus.fill_err   = 1'b0;
      tick();
      test_reset();
      test_miss_fill();
      test_hit();
      test_fill_err();
      test_inv_deferred();
      test_stall();
      test_inv_priority();
      test_reset_mid_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
